raptor64_shift_sched: RTL and testbench
=======================================

Name: raptor64_shift_sched

Overview:
- Schedules one shared 64-bit shift/rotate datapath (combinational shifter: SHL, SHRU, SHR, ROL, ROR, ROLAM) between two requesters.
- Requester 0 is the integer execute stage. Requester 1 is the bitfield/multiply-assist unit.
- Round-robin arbitration, registered operands, registered result, one-cycle done pulse per accepted request.
- Sits between the requesters and the shifter instance. The shifter's inputs are driven only by this block.

Parameters:
- WID, 64, data width of a, mask and result.
- AMT_W, 6, shift-amount width; only the low AMT_W bits are used.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req0_i  in  1  requester 0 request; held high until done0_o is seen.
- op0_i  in  3  requester 0 operation: 0 SHL, 1 SHRU, 2 SHR (arithmetic), 3 ROL, 4 ROR, 5 ROLAM, 6-7 invalid.
- a0_i  in  WID  requester 0 operand.
- b0_i  in  AMT_W  requester 0 shift amount.
- mask0_i  in  WID  requester 0 ROLAM mask.
- req1_i, op1_i, a1_i, b1_i, mask1_i  in  same as above  requester 1 request and operands.
- done0_o  out  1  one-cycle pulse: result for requester 0 valid on res_o.
- done1_o  out  1  one-cycle pulse: result for requester 1 valid on res_o.
- res_o  out  WID  registered result, shared by both requesters.
- busy_o  out  1  high in EXEC.
- gnt_o  out  1  index of the requester currently or last served.
- sh_op_o  out  3  operation to the shifter, from the operand register.
- sh_a_o  out  WID  operand to the shifter.
- sh_b_o  out  AMT_W  shift amount to the shifter.
- sh_mask_o  out  WID  mask to the shifter.
- sh_res_i  in  WID  combinational shifter output.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE.
  - done0_o=done1_o=0, res_o=0, busy_o=0, gnt_o=1.
  - Operand registers and sh_* outputs = 0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE, EXEC, DONE.
- IDLE:
  - If any eligible req is high, accept one: latch its op/a/b/mask into the operand registers, set gnt_o and last_grant to its index, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - busy_o=1; sh_* outputs are driven from the operand registers.
  - At the clock edge, res_o <= sh_res_i, or 0 if op is 6 or 7. Assert done[gnt_o] next cycle. Go to DONE.
  - Requests are not sampled.
- DONE:
  - done[gnt_o]=1 for exactly this cycle; res_o is valid.
  - res_o holds its value until the next EXEC capture.
  - The just-served requester's req is ignored this cycle, since the requester drops req on the edge after done.
  - The other requester, if its req is high, is accepted here (latch, go to EXEC). Otherwise go to IDLE.
- Arbitration:
  - Both reqs eligible and high: grant !last_grant.
  - Single eligible req: grant it.
  - Eligibility rule: a requester is eligible in IDLE always, and in DONE only if it is not gnt_o.
- Latency and throughput:
  - Accept edge T; result captured at edge T+1; done high during cycle T+1 to T+2.
  - Accept-to-done = 2 cycles.
  - Back-to-back alternating requesters sustain one operation per 2 cycles.
- Operands: sampled only on the accept edge. Later changes to a/b/op while the request is in service have no effect.
- Shift amount: b wider than AMT_W is not possible; amount 0 returns a unchanged for every legal op (ROLAM returns a & mask).
- Invalid op (6, 7): the handshake completes normally; res_o=0.
- Reset mid-operation (EXEC or DONE): abort immediately, no done pulse, state=IDLE. The requester re-issues after reset.
- done0_o and done1_o are never high in the same cycle.

Test Plan:
- Single SHL: req0, op=0, a=1, b=4 -> done0_o exactly 2 cycles after accept, res_o=0x10; done1_o stays 0.
- Arithmetic shift: req1, op=2, a=0x8000_0000_0000_0000, b=4 -> res_o=0xF800_0000_0000_0000. Same operands with op=1 (SHRU) -> 0x0800_0000_0000_0000.
- ROLAM and ROR:
  - op=5, a=0x0123_4567_89AB_CDEF, b=8, mask=0x0000_0000_FFFF_FFFF -> res_o=0x0000_0000_AB_CDEF01.
  - op=4, same a, b=4 -> res_o=0xF012_3456_789A_BCDE.
- Contention: req0 and req1 both high from reset with distinct ops -> requester 0 served first. Requester 1 is accepted in requester 0's DONE cycle; done0_o and done1_o are 2 cycles apart. Continuous contention alternates 0,1,0,1.
- Held request: req0 held high through done0_o with req1 low -> no second accept in the DONE cycle. Re-accepted from IDLE one cycle later.
- Reset and invalid op:
  - rst_ni pulsed low during EXEC -> no done pulse, res_o=0, busy_o=0 asynchronously.
  - Afterwards op=7 request -> done pulses, res_o=0.

Source files
------------

// File: rtl/raptor64_shift_sched_if.sv
// ---------------------------------------------------------------------------
// raptor64_shift_sched_if
//   Bundle of every non-clock signal around the shift scheduler.
//   Requester side : req/op/a/b/mask per requester in, done/res/busy/gnt out.
//   Shifter side   : sh_op/sh_a/sh_b/sh_mask to the shifter, sh_res back.
//   Modports:
//     slave  - the scheduler itself
//     master - everything around it (requesters and the shifter instance)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface raptor64_shift_sched_if #(
  parameter int WID   = 64,
  parameter int AMT_W = 6
);
  // requester 0
  logic             req0_i;
  logic [2:0]       op0_i;
  logic [WID-1:0]   a0_i;
  logic [AMT_W-1:0] b0_i;
  logic [WID-1:0]   mask0_i;
  // requester 1
  logic             req1_i;
  logic [2:0]       op1_i;
  logic [WID-1:0]   a1_i;
  logic [AMT_W-1:0] b1_i;
  logic [WID-1:0]   mask1_i;
  // completion / status
  logic             done0_o;
  logic             done1_o;
  logic [WID-1:0]   res_o;
  logic             busy_o;
  logic             gnt_o;
  // shifter connection
  logic [2:0]       sh_op_o;
  logic [WID-1:0]   sh_a_o;
  logic [AMT_W-1:0] sh_b_o;
  logic [WID-1:0]   sh_mask_o;
  logic [WID-1:0]   sh_res_i;

  modport slave (
    input  req0_i, op0_i, a0_i, b0_i, mask0_i,
    input  req1_i, op1_i, a1_i, b1_i, mask1_i,
    input  sh_res_i,
    output done0_o, done1_o, res_o, busy_o, gnt_o,
    output sh_op_o, sh_a_o, sh_b_o, sh_mask_o
  );

  modport master (
    output req0_i, op0_i, a0_i, b0_i, mask0_i,
    output req1_i, op1_i, a1_i, b1_i, mask1_i,
    output sh_res_i,
    input  done0_o, done1_o, res_o, busy_o, gnt_o,
    input  sh_op_o, sh_a_o, sh_b_o, sh_mask_o
  );
endinterface

// File: rtl/raptor64_shift_sched.sv
// ---------------------------------------------------------------------------
// raptor64_shift_sched
//   Round-robin scheduler sharing one combinational 64-bit shift/rotate unit
//   between the integer execute stage (requester 0) and the bitfield /
//   multiply-assist unit (requester 1).
//   Flow: IDLE/DONE accept -> EXEC (shifter evaluates registered operands,
//   result captured) -> DONE (one-cycle done pulse for the served requester).
//   Ports:
//     clk_i  - clock, rising edge
//     rst_ni - asynchronous active-low reset
//     bus    - raptor64_shift_sched_if.slave: requests, operands, done pulses,
//              shared result, busy/grant status and the shifter connection
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module raptor64_shift_sched #(
  parameter int WID   = 64,
  parameter int AMT_W = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  raptor64_shift_sched_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic             gnt_q,   gnt_d;    // doubles as last_grant
  logic [2:0]       op_q,    op_d;
  logic [WID-1:0]   a_q,     a_d;
  logic [AMT_W-1:0] b_q,     b_d;
  logic [WID-1:0]   mask_q,  mask_d;
  logic [WID-1:0]   res_q,   res_d;

  logic elig0, elig1, cand0, cand1, accept, pick;

  // Arbitration. In DONE the requester just served is still holding req for
  // one more cycle, so it is masked out; only the other side can be taken.
  always_comb begin
    elig0  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && (gnt_q != 1'b0));
    elig1  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && (gnt_q != 1'b1));
    cand0  = bus.req0_i & elig0;
    cand1  = bus.req1_i & elig1;
    accept = cand0 | cand1;
    // On a tie the last-served requester loses; otherwise take whoever asks.
    pick   = (cand0 & cand1) ? ~gnt_q : cand1;
  end

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = ST_EXEC;
          gnt_d   = pick;
          op_d    = pick ? bus.op1_i   : bus.op0_i;
          a_d     = pick ? bus.a1_i    : bus.a0_i;
          b_d     = pick ? bus.b1_i    : bus.b0_i;
          mask_d  = pick ? bus.mask1_i : bus.mask0_i;
        end
      end
      ST_EXEC: begin
        // Ops 6 and 7 are undefined for the shifter; complete them with zero.
        res_d   = (op_q[2] & op_q[1]) ? '0 : bus.sh_res_i;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the operand registers are reset too, because they drive the
  // shifter directly and its inputs must read zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      res_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
    end
  end

  assign bus.done0_o   = (state_q == ST_DONE) && !gnt_q;
  assign bus.done1_o   = (state_q == ST_DONE) &&  gnt_q;
  assign bus.busy_o    = (state_q == ST_EXEC);
  assign bus.gnt_o     = gnt_q;
  assign bus.res_o     = res_q;
  assign bus.sh_op_o   = op_q;
  assign bus.sh_a_o    = a_q;
  assign bus.sh_b_o    = b_q;
  assign bus.sh_mask_o = mask_q;

endmodule

// File: tb/tb_raptor64_shift_sched.sv
// ---------------------------------------------------------------------------
// tb_raptor64_shift_sched
//   Self-checking bench for raptor64_shift_sched. The bench also plays the
//   shifter (behavioural shift/rotate feeding sh_res_i) and keeps a
//   job-level model of the scheduler: one job in flight, result two edges
//   after acceptance, round-robin pick among requesters allowed to start.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_raptor64_shift_sched;
  localparam int WID   = 64;
  localparam int AMT_W = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  raptor64_shift_sched_if #(.WID(WID), .AMT_W(AMT_W)) bus ();

  raptor64_shift_sched #(.WID(WID), .AMT_W(AMT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural shifter: rotates built from a doubled word.
  function automatic logic [63:0] shf(input logic [2:0] op, input logic [63:0] a,
                                      input logic [5:0] b, input logic [63:0] m);
    logic [127:0] rl;
    logic [127:0] rr;
    rl = {a, a} << b;
    rr = {a, a} >> b;
    case (op)
      3'd0:    return a << b;
      3'd1:    return a >> b;
      3'd2:    return $signed(a) >>> b;
      3'd3:    return rl[127:64];
      3'd4:    return rr[63:0];
      3'd5:    return rl[127:64] & m;
      default: return a ^ 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  function automatic logic [63:0] expect_res(input logic [2:0] op, input logic [63:0] a,
                                             input logic [5:0] b, input logic [63:0] m);
    return (op >= 3'd6) ? 64'd0 : shf(op, a, b, m);
  endfunction

  assign bus.sh_res_i = shf(bus.sh_op_o, bus.sh_a_o, bus.sh_b_o, bus.sh_mask_o);

  // ---------------- job-level reference model ----------------
  int          m_job;      // requester whose job is in flight, -1 if none
  bit          m_age;      // 0: result not yet captured, 1: done cycle
  bit          m_last;     // last requester served
  logic [63:0] m_res;      // expected res_o
  logic [63:0] m_job_res;  // result owed to the job in flight

  function automatic void model_reset();
    m_job = -1; m_age = 0; m_last = 1'b1; m_res = '0; m_job_res = '0;
  endfunction

  // Advance the model across one rising edge using the inputs now driven.
  function automatic void model_edge();
    bit in_done, c0, c1;
    int pick;
    in_done = (m_job >= 0) && m_age;
    if (m_job >= 0 && !m_age) begin
      m_res = m_job_res;
      m_age = 1'b1;
    end else begin
      c0 = bus.req0_i && !(in_done && m_job == 0);
      c1 = bus.req1_i && !(in_done && m_job == 1);
      if (c0 || c1) begin
        pick      = (c0 && c1) ? (m_last ? 0 : 1) : (c0 ? 0 : 1);
        m_job     = pick;
        m_last    = (pick == 1);
        m_age     = 1'b0;
        m_job_res = pick ? expect_res(bus.op1_i, bus.a1_i, bus.b1_i, bus.mask1_i)
                         : expect_res(bus.op0_i, bus.a0_i, bus.b0_i, bus.mask0_i);
      end else begin
        m_job = -1;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic req, input logic [2:0] op,
                         input logic [63:0] a, input logic [5:0] b, input logic [63:0] m);
    if (idx == 0) begin
      bus.req0_i = req; bus.op0_i = op; bus.a0_i = a; bus.b0_i = b; bus.mask0_i = m;
    end else begin
      bus.req1_i = req; bus.op1_i = op; bus.a1_i = a; bus.b1_i = b; bus.mask1_i = m;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 3'd0, '0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one request, wait (bounded) for its done, return result/latency.
  task automatic run_one(input int idx, input logic [2:0] op, input logic [63:0] a,
                         input logic [5:0] b, input logic [63:0] m,
                         output logic [63:0] res, output int lat, output bit other);
    bit mine;
    lat = 0; other = 0; mine = 0;
    set_req(idx, 1'b1, op, a, b, m);
    while (!mine && lat < 10) begin
      tick();
      lat++;
      mine = (idx == 0) ? bus.done0_o : bus.done1_o;
      if (((idx == 0) ? bus.done1_o : bus.done0_o) === 1'b1) other = 1;
    end
    res = bus.res_o;
    set_req(idx, 1'b0, op, a, b, m);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 3'd0, '0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.done0_o !== 1'b0) begin errors++; $display("FAIL reset_done0 got %b exp 0", bus.done0_o); end
    checks++; if (bus.done1_o !== 1'b0) begin errors++; $display("FAIL reset_done1 got %b exp 0", bus.done1_o); end
    checks++; if (bus.res_o !== 64'd0) begin errors++; $display("FAIL reset_res got %h exp 0", bus.res_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
    checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL reset_gnt got %b exp 1", bus.gnt_o); end
    checks++; if ({bus.sh_op_o, bus.sh_a_o, bus.sh_b_o, bus.sh_mask_o} !== '0) begin
      errors++; $display("FAIL reset_sh got op=%h a=%h b=%h m=%h exp all 0",
                         bus.sh_op_o, bus.sh_a_o, bus.sh_b_o, bus.sh_mask_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_shl();
    logic [63:0] res; int lat; bit other;
    run_one(0, 3'd0, 64'd1, 6'd4, 64'd0, res, lat, other);
    checks++; if (res !== 64'h10) begin errors++; $display("FAIL shl_res got %h exp 10", res); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL shl_latency got %0d exp 2", lat); end
    checks++; if (other !== 1'b0) begin errors++; $display("FAIL shl_done1_seen got %b exp 0", other); end
    checks++; if (bus.done0_o !== 1'b0) begin errors++; $display("FAIL shl_done0_one_cycle got %b exp 0", bus.done0_o); end
  endtask

  typedef struct {
    int          idx;
    logic [2:0]  op;
    logic [63:0] a;
    logic [5:0]  b;
    logic [63:0] m;
    logic [63:0] exp;
  } vec_t;

  task automatic test_shift_ops();
    vec_t v[10];
    logic [63:0] res; int lat; bit other;
    v = '{
      '{1, 3'd2, 64'h8000_0000_0000_0000, 6'd4,  64'd0,                  64'hF800_0000_0000_0000},
      '{1, 3'd1, 64'h8000_0000_0000_0000, 6'd4,  64'd0,                  64'h0800_0000_0000_0000},
      '{0, 3'd5, 64'h0123_4567_89AB_CDEF, 6'd8,  64'h0000_0000_FFFF_FFFF, 64'h0000_0000_ABCD_EF01},
      '{0, 3'd4, 64'h0123_4567_89AB_CDEF, 6'd4,  64'd0,                  64'hF012_3456_789A_BCDE},
      '{1, 3'd3, 64'h0123_4567_89AB_CDEF, 6'd4,  64'd0,                  64'h1234_5678_9ABC_DEF0},
      '{0, 3'd2, 64'h8000_0000_0000_0000, 6'd0,  64'd0,                  64'h8000_0000_0000_0000},
      '{1, 3'd5, 64'h0123_4567_89AB_CDEF, 6'd0,  64'hFFFF_0000_FFFF_0000, 64'h0123_0000_89AB_0000},
      '{0, 3'd4, 64'h0123_4567_89AB_CDEF, 6'd0,  64'd0,                  64'h0123_4567_89AB_CDEF},
      '{1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'd0,                  64'h8000_0000_0000_0000},
      '{0, 3'd2, 64'h8000_0000_0000_0000, 6'd63, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFF}
    };
    for (int i = 0; i < 10; i++) begin
      run_one(v[i].idx, v[i].op, v[i].a, v[i].b, v[i].m, res, lat, other);
      checks++;
      if (res !== v[i].exp || lat !== 2) begin
        errors++;
        $display("FAIL shift_op_%0d got res=%h lat=%0d exp res=%h lat=2", i, res, lat, v[i].exp);
      end
    end
  endtask

  task automatic test_contention();
    int who[$];
    int when[$];
    logic [63:0] rv[$];
    int both = 0;
    do_reset();
    set_req(0, 1'b1, 3'd0, 64'd3,     6'd1, 64'd0);  // -> 6
    set_req(1, 1'b1, 3'd1, 64'h100,   6'd4, 64'd0);  // -> 0x10
    for (int cyc = 1; cyc <= 20 && who.size() < 6; cyc++) begin
      tick();
      if (bus.done0_o === 1'b1 && bus.done1_o === 1'b1) both++;
      if (bus.done0_o === 1'b1) begin who.push_back(0); when.push_back(cyc); rv.push_back(bus.res_o); end
      else if (bus.done1_o === 1'b1) begin who.push_back(1); when.push_back(cyc); rv.push_back(bus.res_o); end
    end
    checks++; if (who.size() !== 6) begin errors++; $display("FAIL contention_count got %0d exp 6", who.size()); end
    checks++; if (both !== 0) begin errors++; $display("FAIL contention_both_done got %0d exp 0", both); end
    if (who.size() > 0) begin
      checks++;
      if (when[0] !== 2 || who[0] !== 0) begin
        errors++; $display("FAIL contention_first got req%0d at %0d exp req0 at 2", who[0], when[0]);
      end
    end
    for (int k = 1; k < who.size(); k++) begin
      checks++;
      if (who[k] !== (k % 2) || (when[k] - when[k-1]) !== 2 || rv[k] !== ((k % 2) ? 64'h10 : 64'd6)) begin
        errors++;
        $display("FAIL contention_seq_%0d got req%0d gap=%0d res=%h exp req%0d gap=2 res=%h",
                 k, who[k], when[k] - when[k-1], rv[k], k % 2, (k % 2) ? 64'h10 : 64'd6);
      end
    end
    set_req(0, 1'b0, 3'd0, '0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0, '0);
    repeat (3) tick();
  endtask

  task automatic test_held();
    do_reset();
    set_req(0, 1'b1, 3'd0, 64'd5, 6'd2, 64'd0);   // 5<<2 = 20
    tick();
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL held_exec1 busy got %b exp 1", bus.busy_o); end
    tick();
    checks++; if (bus.done0_o !== 1'b1 || bus.res_o !== 64'd20) begin
      errors++; $display("FAIL held_done1 got done0=%b res=%h exp 1 14", bus.done0_o, bus.res_o);
    end
    tick();  // req still high, but it was just served: back to IDLE
    checks++; if (bus.busy_o !== 1'b0 || bus.done0_o !== 1'b0) begin
      errors++; $display("FAIL held_no_reaccept got busy=%b done0=%b exp 0 0", bus.busy_o, bus.done0_o);
    end
    bus.a0_i = 64'd7;                             // re-issued op: 7<<2 = 28
    tick();
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL held_reaccept busy got %b exp 1", bus.busy_o); end
    bus.a0_i = 64'd9;                             // too late, already latched
    bus.b0_i = 6'd5;
    tick();
    checks++; if (bus.done0_o !== 1'b1 || bus.res_o !== 64'd28) begin
      errors++; $display("FAIL held_done2 got done0=%b res=%h exp 1 1c", bus.done0_o, bus.res_o);
    end
    set_req(0, 1'b0, 3'd0, '0, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid_and_invalid();
    logic [63:0] res; int lat; bit other;
    bit saw_done;
    set_req(1, 1'b1, 3'd0, 64'd1, 6'd1, 64'd0);
    tick();
    checks++; if (bus.busy_o !== 1'b1 || bus.res_o === 64'd0) begin
      errors++; $display("FAIL rstmid_pre got busy=%b res=%h exp busy 1 res nonzero", bus.busy_o, bus.res_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.res_o !== 64'd0 || bus.gnt_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_async got busy=%b res=%h gnt=%b exp 0 0 1", bus.busy_o, bus.res_o, bus.gnt_o);
    end
    model_reset();
    set_req(1, 1'b0, 3'd0, '0, '0, '0);
    saw_done = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done0_o === 1'b1 || bus.done1_o === 1'b1) saw_done = 1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    if (bus.done0_o === 1'b1 || bus.done1_o === 1'b1) saw_done = 1;
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got %b exp 0", saw_done); end
    run_one(0, 3'd0, 64'd1, 6'd1, 64'd0, res, lat, other);
    checks++; if (res !== 64'd2) begin errors++; $display("FAIL post_reset_op got %h exp 2", res); end
    run_one(1, 3'd7, 64'h0123_4567_89AB_CDEF, 6'd3, 64'hFF, res, lat, other);
    checks++; if (res !== 64'd0 || lat !== 2) begin
      errors++; $display("FAIL invalid_op7 got res=%h lat=%0d exp 0 2", res, lat);
    end
    run_one(0, 3'd0, 64'd3, 6'd0, 64'd0, res, lat, other);
    run_one(0, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 64'd0, res, lat, other);
    checks++; if (res !== 64'd0 || lat !== 2) begin
      errors++; $display("FAIL invalid_op6 got res=%h lat=%0d exp 0 2", res, lat);
    end
  endtask

  task automatic new_req(input int idx);
    set_req(idx, 1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom},
            6'($urandom_range(0, 63)), {$urandom, $urandom});
  endtask

  task automatic test_random();
    logic e_done0, e_done1, e_busy;
    logic d;
    logic r;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        d = (i == 0) ? bus.done0_o : bus.done1_o;
        r = (i == 0) ? bus.req0_i  : bus.req1_i;
        if (r && d) begin
          if ($urandom_range(0, 1) == 0) new_req(i);
          else set_req(i, 1'b0, 3'd0, '0, '0, '0);
        end else if (!r && $urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
      tick();
      e_done0 = (m_job == 0) && m_age;
      e_done1 = (m_job == 1) && m_age;
      e_busy  = (m_job >= 0) && !m_age;
      checks++;
      if (bus.done0_o !== e_done0 || bus.done1_o !== e_done1 || bus.busy_o !== e_busy ||
          bus.gnt_o !== m_last || bus.res_o !== m_res) begin
        errors++;
        $display("FAIL random_cyc%0d got d0=%b d1=%b busy=%b gnt=%b res=%h exp d0=%b d1=%b busy=%b gnt=%b res=%h",
                 cyc, bus.done0_o, bus.done1_o, bus.busy_o, bus.gnt_o, bus.res_o,
                 e_done0, e_done1, e_busy, m_last, m_res);
      end
    end
    set_req(0, 1'b0, 3'd0, '0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0, '0);
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_shl();
    test_shift_ops();
    test_contention();
    test_held();
    test_reset_mid_and_invalid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
